cpu_mem_split_ctrl: RTL
=======================

CPU_MEM_SPLIT_CTRL -- requirements
Module: cpu_mem_split_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, meaning memory data width in bits (32 or 64); NB=DW/8 byte lanes, LB=log2(NB).
REQ-002 SHALL have parameter AW, default 32, meaning CPU byte-address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for i_mem_ack per bus phase (1..65535).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 i_clk  in  1  clock.
REQ-006 i_reset_n  in  1  asynchronous active-low reset.
REQ-007 i_stb  in  1  CPU request strobe.
REQ-008 i_we  in  1  CPU write enable.
REQ-009 i_addr  in  AW  CPU byte address.
REQ-010 i_wdata  in  DW  CPU write data, right-justified.
REQ-011 i_size  in  2  access size: 0=byte, 1=half, 2=word, 3=dword.
REQ-012 i_unsigned  in  1  selects zero-extension of read data (1) or sign-extension (0).
REQ-013 o_stall  out  1  controller busy.
REQ-014 o_ack  out  1  one-cycle completion pulse.
REQ-015 o_err  out  1  error qualifier, valid with o_ack.
REQ-016 o_rdata  out  DW  extended read data.
REQ-017 o_mem_stb  out  1  memory strobe (pipelined wishbone).
REQ-018 o_mem_we  out  1  memory write enable.
REQ-019 o_mem_addr  out  AW-LB  memory word address.
REQ-020 o_mem_wdata  out  DW  memory write data.
REQ-021 o_mem_sel  out  NB  byte-lane enables.
REQ-022 i_mem_rdata  in  DW  memory read data.
REQ-023 i_mem_ack  in  1  memory acknowledge.
REQ-024 i_mem_stall  in  1  memory stall.

Function
REQ-025 Request accepted on a rising edge with i_stb=1 and o_stall=0; addr, wdata, we, size and unsigned are latched; o_stall rises next cycle and stays high through the o_ack cycle.
REQ-026 States: IDLE, REQ, WAIT, RESP.
- IDLE->REQ on acceptance.
- REQ holds o_mem_stb=1 with stable addr/data/sel until sampled with i_mem_stall=0, then ->WAIT with o_mem_stb=0.
- WAIT->REQ (phase 2) on i_mem_ack if the access is split and phase 1 is done; otherwise ->RESP.
- RESP drives o_ack=1 for one cycle, then ->IDLE.
REQ-027 Split: an access SHALL be split when offset=addr[LB-1:0] plus size bytes exceeds NB. Phase 1 uses word W=addr>>LB; phase 2 uses W+1, wrapping modulo 2^(AW-LB).
REQ-028 Write lanes: {2*DW} = wdata<<(8*offset); phase 1 drives the low DW bits, phase 2 the high DW bits. o_mem_sel is derived from the size mask shifted the same way. Unused lanes SHALL be driven as 0.
REQ-029 Read assembly: ({phase2 data, phase1 data} >> 8*offset), truncated to size, then sign- or zero-extended to DW. For an unsplit access, phase-2 data SHALL be treated as 0.
REQ-030 o_rdata SHALL update only at RESP entry for reads and SHALL hold until the next read response. Writes leave o_rdata unchanged.
REQ-031 Latency: o_ack SHALL assert in the cycle after the edge sampling the final i_mem_ack. An unsplit, zero-wait access gives o_ack 3 cycles after the acceptance edge; a split access gives 5.
REQ-032 i_mem_ack SHALL be ignored outside WAIT.
REQ-033 Timeout: a per-phase counter clears on REQ->WAIT. If it reaches TIMEOUT without i_mem_ack, the block SHALL go to RESP with o_err=1, skip phase 2, and leave o_rdata unchanged.
REQ-034 Illegal size (size=3 with DW=32): no bus cycle SHALL be issued; the next state SHALL be RESP with o_err=1.
REQ-035 o_mem_we SHALL equal the latched we while o_mem_stb=1, and SHALL be 0 otherwise.

Reset
REQ-036 On i_reset_n=0, all of the following SHALL clear immediately regardless of state, aborting any split in progress: state=IDLE, o_stall=0, o_ack=0, o_err=0, o_mem_stb=0, o_mem_we=0, o_mem_sel=0, o_mem_addr=0, o_mem_wdata=0, o_rdata=0, timeout counter=0.
REQ-037 The first request after reset release SHALL be accepted normally.

Verification (DW=32)
REQ-038 Word read at 0x100, memory returns 0xDEADBEEF, no stall -> one cycle at addr 0x40, sel 1111; o_rdata=0xDEADBEEF; o_ack for 1 cycle at +3.
REQ-039 Byte read at 0x103, memory returns 0x80FFFFFF -> signed o_rdata=0xFFFFFF80; unsigned o_rdata=0x00000080.
REQ-040 Half write at 0x0B, data 0xA1B2 -> phase 1: addr 0x02, sel 1000, wdata 0xB2000000; phase 2: addr 0x03, sel 0001, wdata 0x000000A1; one o_ack.
REQ-041 Word read at 0x0E, word 3=0x22110000, word 4=0x00004433, with i_mem_stall high for 2 cycles in phase 2 -> o_rdata=0x44332211; o_mem_stb held stable while stalled.
REQ-042 TIMEOUT=8, no i_mem_ack -> o_ack with o_err=1 after 8 WAIT cycles; no phase 2; next request accepted.
REQ-043 Reset asserted after the phase-1 ack of a split -> all outputs reach reset values without a clock edge; a subsequent aligned read completes correctly.

Source files
------------

// File: rtl/cpu_mem_split_ctrl.sv
// ============================================================================
//  Module   : cpu_mem_split_ctrl
//  Purpose  : CPU load/store to pipelined-wishbone bridge that splits
//             misaligned accesses into two word cycles and re-assembles reads.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_mem_split_ctrl #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_stb,
    input  logic               i_we,
    input  logic [AW-1:0]      i_addr,
    input  logic [DW-1:0]      i_wdata,
    input  logic [1:0]         i_size,
    input  logic               i_unsigned,
    output logic               o_stall,
    output logic               o_ack,
    output logic               o_err,
    output logic [DW-1:0]      o_rdata,
    output logic               o_mem_stb,
    output logic               o_mem_we,
    output logic [AW-$clog2(DW/8)-1:0] o_mem_addr,
    output logic [DW-1:0]      o_mem_wdata,
    output logic [DW/8-1:0]    o_mem_sel,
    input  logic [DW-1:0]      i_mem_rdata,
    input  logic               i_mem_ack,
    input  logic               i_mem_stall
);

    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic            phase;
    logic            err_q;
    logic [DW-1:0]   ph1_data;
    logic [15:0]     cnt;
    logic [DW-1:0]   rdata_q;

    logic [LB-1:0]   offset;
    logic [3:0]      nbytes;
    logic [3:0]      nbytes_in;
    logic [NB-1:0]   bmask;
    logic [DW-1:0]   bits;
    logic            split;
    logic            illegal_in;
    logic            last_phase;
    logic            tmo;
    logic [2*DW-1:0] wd_wide;
    logic [2*NB-1:0] sel_wide;
    logic [DW-1:0]   rd_lo, rd_hi, rd_sh, rd_ext;
    logic            sign;

    always_comb begin
        offset     = addr_q[LB-1:0];
        nbytes     = 4'd1 << size_q;
        nbytes_in  = 4'd1 << i_size;
        illegal_in = int'(nbytes_in) > NB;
        for (int i = 0; i < NB; i++) begin
            bmask[i]        = 4'(i) < nbytes;
            bits[8*i +: 8]  = {8{bmask[i]}};
        end
        split      = (int'(offset) + int'(nbytes)) > NB;
        last_phase = !(split && !phase);
        tmo        = cnt == 16'(TIMEOUT - 1);
        // Unused lanes must stay zero, so data is masked to size before shifting.
        wd_wide    = {{DW{1'b0}}, wdata_q & bits} << {offset, 3'b000};
        sel_wide   = {{NB{1'b0}}, bmask} << offset;
        rd_lo      = phase ? ph1_data : i_mem_rdata;
        rd_hi      = phase ? i_mem_rdata : '0;
        rd_sh      = DW'({rd_hi, rd_lo} >> {offset, 3'b000});
        // Top bit of the contiguous size mask locates the sign bit.
        sign       = |(rd_sh & bits & ~(bits >> 1));
        rd_ext     = (rd_sh & bits) | ((sign && !uns_q) ? ~bits : '0);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (i_stb) state_nx = illegal_in ? RESP : REQ;
            REQ:  if (!i_mem_stall) state_nx = WAIT;
            WAIT: begin
                if (i_mem_ack)  state_nx = last_phase ? RESP : REQ;
                else if (tmo)   state_nx = RESP;
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            size_q   <= 2'd0;
            uns_q    <= 1'b0;
            phase    <= 1'b0;
            err_q    <= 1'b0;
            ph1_data <= '0;
            cnt      <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: if (i_stb) begin
                    addr_q  <= i_addr;
                    wdata_q <= i_wdata;
                    we_q    <= i_we;
                    size_q  <= i_size;
                    uns_q   <= i_unsigned;
                    phase   <= 1'b0;
                    err_q   <= illegal_in;
                    cnt     <= '0;
                end
                REQ: if (!i_mem_stall) cnt <= '0;
                WAIT: begin
                    if (i_mem_ack) begin
                        if (!last_phase) begin
                            phase    <= 1'b1;
                            ph1_data <= i_mem_rdata;
                        end else if (!we_q) begin
                            rdata_q  <= rd_ext;
                        end
                    end else if (tmo) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_stall     = state != IDLE;
        o_ack       = state == RESP;
        o_err       = (state == RESP) && err_q;
        o_mem_stb   = state == REQ;
        o_mem_we    = o_mem_stb && we_q;
        o_mem_addr  = addr_q[AW-1:LB] + {{(AW-LB-1){1'b0}}, phase};
        o_mem_wdata = phase ? wd_wide[2*DW-1:DW] : wd_wide[DW-1:0];
        o_mem_sel   = o_mem_stb ? (phase ? sel_wide[2*NB-1:NB] : sel_wide[NB-1:0]) : '0;
        o_rdata     = rdata_q;
    end

endmodule

`default_nettype wire
